// File: rtl/power_meter_axil_regs.sv
// AXI4-Lite register file and |x|^2 accumulation engine for the power meter.
// Four 32-bit words: CTRL, LEN, RESULT, STATUS; optional done interrupt.
module power_meter_axil_regs #(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 4,
    parameter int unsigned SAMPLE_W           = 16,
    parameter int unsigned ACC_W              = 48,
    parameter int unsigned SHIFT              = 0
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [2:0]                      s_axi_awprot,
    input  logic                            s_axi_awvalid,
    output logic                            s_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                            s_axi_wvalid,
    output logic                            s_axi_wready,
    output logic [1:0]                      s_axi_bresp,
    output logic                            s_axi_bvalid,
    input  logic                            s_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [2:0]                      s_axi_arprot,
    input  logic                            s_axi_arvalid,
    output logic                            s_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                      s_axi_rresp,
    output logic                            s_axi_rvalid,
    input  logic                            s_axi_rready,
    input  logic [SAMPLE_W-1:0]             sample_i,
    input  logic [SAMPLE_W-1:0]             sample_q,
    input  logic                            sample_valid,
    output logic                            irq
);

    localparam int unsigned DW = C_S_AXI_DATA_WIDTH;
    localparam int unsigned SW = DW / 8;
    localparam int unsigned PW = 2 * SAMPLE_W;
    localparam int unsigned RW = 32;

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_LEN    = 2'd1;
    localparam logic [1:0] A_RESULT = 2'd2;
    localparam logic [1:0] A_STATUS = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic              r_wr_acc;
    logic              r_bvalid;
    logic              r_arready;
    logic              r_rvalid;
    logic [DW-1:0]     r_rdata;
    logic              r_irq_en;
    logic              r_irq;
    logic [DW-1:0]     r_len;
    logic [DW-1:0]     r_len_act;
    logic [DW-1:0]     r_count;
    logic [ACC_W-1:0]  r_acc;
    logic [RW-1:0]     r_result;

    logic              w_wr_fire;
    logic              w_rd_fire;
    logic [1:0]        w_wr_sel;
    logic [DW-1:0]     w_rd_data;
    logic              w_start;
    logic              w_w1c;
    logic              w_irq_en_nxt;
    logic              w_clear;
    logic              w_zero_len;
    logic              w_acc_en;
    logic              w_finish;
    logic signed [PW-1:0] w_i_ext;
    logic signed [PW-1:0] w_q_ext;
    logic signed [PW-1:0] w_ii;
    logic signed [PW-1:0] w_qq;
    logic [PW:0]       w_sq;
    logic [ACC_W-1:0]  w_acc_sum;
    logic [ACC_W-1:0]  w_shifted;
    logic [RW-1:0]     w_result_sat;
    logic              w_unused;

    assign s_axi_awready = r_wr_acc;
    assign s_axi_wready  = r_wr_acc;
    assign s_axi_bvalid  = r_bvalid;
    assign s_axi_bresp   = 2'b00;
    assign s_axi_arready = r_arready;
    assign s_axi_rvalid  = r_rvalid;
    assign s_axi_rdata   = r_rdata;
    assign s_axi_rresp   = 2'b00;
    assign irq           = r_irq;

    assign w_unused = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    assign w_wr_fire = r_wr_acc && s_axi_awvalid && s_axi_wvalid;
    assign w_rd_fire = r_arready && s_axi_arvalid;
    assign w_wr_sel  = s_axi_awaddr[3:2];
    assign w_start   = w_wr_fire && (w_wr_sel == A_CTRL) && s_axi_wstrb[0] && s_axi_wdata[0];
    assign w_w1c     = w_wr_fire && (w_wr_sel == A_STATUS) && s_axi_wstrb[0] && s_axi_wdata[1];

    // Squares of signed samples are non-negative, so the sum is held unsigned.
    assign w_i_ext      = PW'($signed(sample_i));
    assign w_q_ext      = PW'($signed(sample_q));
    assign w_ii         = w_i_ext * w_i_ext;
    assign w_qq         = w_q_ext * w_q_ext;
    assign w_sq         = {1'b0, w_ii} + {1'b0, w_qq};
    assign w_acc_sum    = r_acc + ACC_W'(w_sq);
    assign w_shifted    = w_acc_sum >> SHIFT;
    assign w_result_sat = (|w_shifted[ACC_W-1:RW]) ? '1 : w_shifted[RW-1:0];

    // Write and read handshakes; each channel keeps one transaction in flight.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_wr_acc  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_wr_acc  <= !r_wr_acc && s_axi_awvalid && s_axi_wvalid && !r_bvalid;
            if (w_wr_fire) begin
                r_bvalid <= 1'b1;
            end else if (s_axi_bready) begin
                r_bvalid <= 1'b0;
            end
            r_arready <= !r_arready && s_axi_arvalid && !r_rvalid;
            if (w_rd_fire) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rd_data;
            end else if (s_axi_rready) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    always_comb begin
        w_rd_data = '0;
        case (s_axi_araddr[3:2])
            A_CTRL:   w_rd_data = DW'({r_irq_en, 1'b0});
            A_LEN:    w_rd_data = r_len;
            A_RESULT: w_rd_data = DW'(r_result);
            A_STATUS: w_rd_data = DW'({r_state == ST_DONE, r_state == ST_RUN});
            default:  w_rd_data = '0;
        endcase
    end

    always_comb begin
        w_irq_en_nxt = r_irq_en;
        if (w_wr_fire && (w_wr_sel == A_CTRL) && s_axi_wstrb[0]) begin
            w_irq_en_nxt = s_axi_wdata[1];
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Measurement sequencing; DONE is the state itself, cleared by START or W1C.
    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        w_zero_len  = 1'b0;
        w_acc_en    = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_start) begin
                    w_clear = 1'b1;
                    if (r_len == '0) begin
                        w_zero_len  = 1'b1;
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_RUN;
                    end
                end else if ((r_state == ST_DONE) && w_w1c) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (sample_valid) begin
                    w_acc_en = 1'b1;
                    if (r_count == (r_len_act - DW'(1))) begin
                        w_finish    = 1'b1;
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_irq_en  <= 1'b0;
            r_irq     <= 1'b0;
            r_len     <= '0;
            r_len_act <= '0;
            r_count   <= '0;
            r_acc     <= '0;
            r_result  <= '0;
        end else begin
            r_irq_en <= w_irq_en_nxt;
            r_irq    <= (w_state_nxt == ST_DONE) && w_irq_en_nxt;
            if (w_wr_fire && (w_wr_sel == A_LEN)) begin
                for (int b = 0; b < SW; b++) begin
                    if (s_axi_wstrb[b]) begin
                        r_len[8*b +: 8] <= s_axi_wdata[8*b +: 8];
                    end
                end
            end
            if (w_clear) begin
                r_acc     <= '0;
                r_count   <= '0;
                r_len_act <= r_len;
                if (w_zero_len) begin
                    r_result <= '0;
                end
            end else if (w_acc_en) begin
                r_acc   <= w_acc_sum;
                r_count <= r_count + DW'(1);
                if (w_finish) begin
                    r_result <= w_result_sat;
                end
            end
        end
    end

endmodule
